// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and read-return owner tags.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        STARVED = 2'd1,
        LOCKED  = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Delays each granted read by RD_LAT cycles and steers its return strobe to the requester that issued it.
module mem_port_arbiter_rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic owner,
    output logic cpu_rvalid,
    output logic dbg_rvalid
);

    rd_tag_t pipe [RD_LAT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= load;
            pipe[0].owner <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign cpu_rvalid = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].owner == OWN_CPU);
    assign dbg_rvalid = pipe[RD_LAT-1].valid && (pipe[RD_LAT-1].owner == OWN_DBG);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU pipeline and the debug/loader port,
// tags read returns to their owner and reports CPU stall cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [7:0]       cpu_addr,
    input  logic [7:0]       cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [7:0]       dbg_addr,
    input  logic [7:0]       dbg_wdata,
    input  logic             dbg_lock,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_wren,
    output logic             mem_rden,
    input  logic [7:0]       mem_q,
    output logic [7:0]       mem_rdata,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             locked
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);

    arb_state_t    state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic          cpu_win, dbg_win;

    // Handshake: a requester holds req (with its address/data/we stable) until it sees gnt in the
    // same cycle; req && gnt consumes the access in that cycle, and a read's data appears on
    // mem_rdata RD_LAT cycles later, qualified by that requester's rvalid.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        case (state)
            NORMAL: begin
                cpu_win = cpu_req;
                dbg_win = dbg_req && !cpu_req;
            end
            STARVED: begin
                dbg_win = dbg_req;
                cpu_win = cpu_req && !dbg_req;
            end
            LOCKED: begin
                dbg_win = dbg_req;
            end
            default: begin
                cpu_win = 1'b0;
                dbg_win = 1'b0;
            end
        endcase
    end

    // Grants are combinational, so they are masked while reset is held low.
    assign cpu_gnt   = reset && cpu_win;
    assign dbg_gnt   = reset && dbg_win;
    assign cpu_stall = reset && cpu_req && !cpu_gnt;
    assign locked    = (state == LOCKED);
    assign mem_rdata = reset ? mem_q : 8'h00;

    always_comb begin
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (dbg_gnt && dbg_lock) begin
                    state_nxt = LOCKED;
                end else if (cpu_gnt && dbg_req && (starve == STARVE_LAST)) begin
                    state_nxt = STARVED;
                end
            end
            STARVED: begin
                if (dbg_gnt) begin
                    state_nxt = dbg_lock ? LOCKED : NORMAL;
                end else if (!dbg_req) begin
                    state_nxt = NORMAL;
                end
            end
            LOCKED: begin
                if (!dbg_lock) begin
                    state_nxt = NORMAL;
                end
            end
            default: state_nxt = NORMAL;
        endcase
    end

    always_comb begin
        starve_nxt = starve;
        if (dbg_gnt || !dbg_req) begin
            starve_nxt = '0;
        end else if (cpu_gnt && (starve != STARVE_TOP)) begin
            starve_nxt = starve + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= NORMAL;
            starve    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            starve <= starve_nxt;
            if (cpu_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = 8'h00;
        mem_data = 8'h00;
        mem_wren = 1'b0;
        mem_rden = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_data = cpu_wdata;
            mem_wren = cpu_we;
            mem_rden = !cpu_we;
        end else if (dbg_gnt) begin
            mem_addr = dbg_addr;
            mem_data = dbg_wdata;
            mem_wren = dbg_we;
            mem_rden = !dbg_we;
        end
    end

    mem_port_arbiter_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) rd_tag_pipe (
        .clock      (clock),
        .reset      (reset),
        .load       (mem_rden),
        .owner      (dbg_gnt ? OWN_DBG : OWN_CPU),
        .cpu_rvalid (cpu_rvalid),
        .dbg_rvalid (dbg_rvalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, with a per-cycle
// behavioural model of arbitration, memory contents and read returns.
module tb_mem_port_arbiter;

    localparam int     RD_LAT     = 2;
    localparam int     STARVE_MAX = 4;
    localparam int     CNT_W      = 16;
    localparam longint STALL_MAX  = (longint'(1) << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0]       cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic             cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic             mem_wren, mem_rden, locked;
    logic [7:0]       mem_addr, mem_data, mem_q, mem_rdata;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    mem_port_arbiter #(
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q),
        .mem_rdata  (mem_rdata),
        .stall_cnt  (stall_cnt),
        .locked     (locked)
    );

    // Synchronous RAM with RD_LAT read latency; contents reload to a known pattern during reset.
    logic [7:0] ram    [256];
    logic [7:0] q_pipe [RD_LAT];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_data;
        end
        q_pipe[0] <= mem_rden ? ram[mem_addr] : q_pipe[0];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign mem_q = q_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    logic [40:0] exp_q [$];          // {due_cycle[31:0], owner_is_dbg, data[7:0]}
    logic [40:0] head;
    logic [7:0]  model_mem [256];
    bit          m_held, m_dbg_first;
    int          m_wins;
    longint      m_stalls;
    int          cyc = 0;
    bit          e_cg, e_dg, e_st, e_crv, e_drv, e_ew, e_er;
    logic [7:0]  e_ea, e_ed, e_rd;
    logic [23:0] e_pack, a_pack;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            a_pack = {cpu_gnt, dbg_gnt, cpu_stall, cpu_rvalid, dbg_rvalid, locked,
                      mem_wren, mem_rden, mem_addr, mem_data};
            if (!reset) begin
                check("reset_outputs", 32'(a_pack), 0);
                check("reset_stall_cnt", 32'(stall_cnt), 0);
                check("reset_mem_rdata", 32'(mem_rdata), 0);
                m_held = 0;
                m_dbg_first = 0;
                m_wins = 0;
                m_stalls = 0;
                exp_q.delete();
                for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'h5A;
            end else begin
                if (m_held) begin
                    e_cg = 0;
                    e_dg = dbg_req;
                end else if (m_dbg_first) begin
                    e_dg = dbg_req;
                    e_cg = cpu_req && !dbg_req;
                end else begin
                    e_cg = cpu_req;
                    e_dg = dbg_req && !cpu_req;
                end
                e_st = cpu_req && !e_cg;
                e_ea = 8'h00; e_ed = 8'h00; e_ew = 0; e_er = 0;
                if (e_cg) begin
                    e_ea = cpu_addr; e_ed = cpu_wdata; e_ew = cpu_we; e_er = !cpu_we;
                end else if (e_dg) begin
                    e_ea = dbg_addr; e_ed = dbg_wdata; e_ew = dbg_we; e_er = !dbg_we;
                end
                e_crv = 0; e_drv = 0; e_rd = 8'h00;
                if (exp_q.size() > 0) begin
                    head = exp_q[0];
                    if (head[40:9] == 32'(cyc)) begin
                        e_rd = head[7:0];
                        if (head[8]) e_drv = 1;
                        else e_crv = 1;
                        void'(exp_q.pop_front());
                    end
                end
                e_pack = {e_cg, e_dg, e_st, e_crv, e_drv, m_held, e_ew, e_er, e_ea, e_ed};
                check("outputs", 32'(a_pack), 32'(e_pack));
                check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
                if (e_crv || e_drv) check("mem_rdata", 32'(mem_rdata), 32'(e_rd));

                if (e_er) exp_q.push_back({32'(cyc + RD_LAT), e_dg, model_mem[e_ea]});
                if (e_ew) model_mem[e_ea] = e_ed;
                if (e_st && (m_stalls < STALL_MAX)) m_stalls++;
                if (m_held) begin
                    if (!dbg_lock) m_held = 0;
                end else if (e_dg && dbg_lock) begin
                    m_held = 1;
                    m_dbg_first = 0;
                end else if (m_dbg_first) begin
                    if (e_dg || !dbg_req) m_dbg_first = 0;
                end else if (e_cg && dbg_req && (m_wins == STARVE_MAX - 1)) begin
                    m_dbg_first = 1;
                end
                if (e_dg || !dbg_req) m_wins = 0;
                else if (e_cg) m_wins++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 0; dbg_we = 0; dbg_addr = 8'h00; dbg_wdata = 8'h00; dbg_lock = 0;
    endtask

    task automatic do_reset();
        tick();
        idle();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    bit last_cg, last_dg;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with requests pending: nothing may be granted.
        idle();
        cpu_req = 1;
        dbg_req = 1;
        @(negedge clock);
        check("rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("rst_dbg_gnt", 32'(dbg_gnt), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_locked", 32'(locked), 0);

        // CPU-only read of 0x10.
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clock);
        check("t1_cpu_gnt", 32'(cpu_gnt), 1);
        check("t1_mem_rden", 32'(mem_rden), 1);
        check("t1_mem_addr", 32'(mem_addr), 32'h10);
        tick();
        cpu_req = 0;
        @(negedge clock);
        check("t1_early_rvalid", 32'(cpu_rvalid), 0);
        repeat (RD_LAT - 1) tick();
        @(negedge clock);
        check("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("t1_dbg_rvalid", 32'(dbg_rvalid), 0);
        check("t1_rdata", 32'(mem_rdata), 32'h4A);

        // Continuous contention: debug wins every fifth cycle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
            dbg_req = 1; dbg_we = 0; dbg_addr = 8'h31;
            @(negedge clock);
            check("t2_cpu_gnt", 32'(cpu_gnt), 32'((c % 5) != 4));
            check("t2_dbg_gnt", 32'(dbg_gnt), 32'((c % 5) == 4));
        end
        tick();
        idle();
        @(negedge clock);
        check("t2_stall_cnt", 32'(stall_cnt), 2);

        // Locked debug burst, then release and CPU readback.
        tick();
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h20; dbg_wdata = 8'hA5; dbg_lock = 1;
        @(negedge clock);
        check("t3_dbg_gnt", 32'(dbg_gnt), 1);
        check("t3_mem_wren", 32'(mem_wren), 1);
        check("t3_mem_data", 32'(mem_data), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
            dbg_addr = 8'(8'h21 + i); dbg_wdata = 8'(i);
            @(negedge clock);
            check("t3_locked_cpu_gnt", 32'(cpu_gnt), 0);
            check("t3_locked", 32'(locked), 1);
        end
        tick();
        dbg_req = 0; dbg_lock = 0;
        @(negedge clock);
        check("t3_release_cycle_locked", 32'(locked), 1);
        check("t3_release_cycle_cpu_gnt", 32'(cpu_gnt), 0);
        tick();
        @(negedge clock);
        check("t3_after_release_cpu_gnt", 32'(cpu_gnt), 1);
        check("t3_after_release_locked", 32'(locked), 0);
        tick();
        cpu_req = 0;
        repeat (RD_LAT - 1) tick();
        @(negedge clock);
        check("t3_readback_rvalid", 32'(cpu_rvalid), 1);
        check("t3_readback_data", 32'(mem_rdata), 32'hA5);

        // Alternating CPU/debug reads every cycle.
        for (int c = 0; c < 8 + RD_LAT; c++) begin
            tick();
            cpu_req = (c < 8) && (c % 2 == 0); cpu_we = 0; cpu_addr = 8'(8'h40 + c);
            dbg_req = (c < 8) && (c % 2 == 1); dbg_we = 0; dbg_addr = 8'(8'h40 + c);
            @(negedge clock);
            if (c >= RD_LAT) begin
                check("t4_cpu_rvalid", 32'(cpu_rvalid), 32'((c - RD_LAT) % 2 == 0));
                check("t4_dbg_rvalid", 32'(dbg_rvalid), 32'((c - RD_LAT) % 2 == 1));
                check("t4_rdata", 32'(mem_rdata), 32'(8'(8'h40 + c - RD_LAT) ^ 8'h5A));
            end
        end

        // Reset while a CPU read is in flight.
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h50; dbg_req = 0;
        @(negedge clock);
        check("t5_cpu_gnt", 32'(cpu_gnt), 1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("t5_rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("t5_rst_stall", 32'(cpu_stall), 0);
        check("t5_rst_stall_cnt", 32'(stall_cnt), 0);
        tick();
        @(negedge clock);
        check("t5_no_rvalid", 32'(cpu_rvalid), 0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("t5_resume_cpu_gnt", 32'(cpu_gnt), 1);
        check("t5_resume_rvalid", 32'(cpu_rvalid), 0);
        tick();
        dbg_req = 1; dbg_we = 0; dbg_addr = 8'h51;
        @(negedge clock);
        check("t5_normal_cpu_gnt", 32'(cpu_gnt), 1);
        check("t5_normal_dbg_gnt", 32'(dbg_gnt), 0);
        tick();
        idle();
        repeat (RD_LAT + 1) tick();

        // Random traffic; requests are held until granted.
        last_cg = 0;
        last_dg = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!cpu_req || last_cg) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 8'($urandom_range(0, 31));
                cpu_wdata = 8'($urandom_range(0, 255));
            end
            if (!dbg_req || last_dg) begin
                dbg_req   = ($urandom_range(0, 2) == 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 8'($urandom_range(0, 31));
                dbg_wdata = 8'($urandom_range(0, 255));
            end
            if (dbg_lock) dbg_lock = ($urandom_range(0, 5) != 0);
            else dbg_lock = ($urandom_range(0, 9) == 0);
            @(negedge clock);
            last_cg = cpu_gnt;
            last_dg = dbg_gnt;
        end

        // stall_cnt saturation while the port is locked.
        do_reset();
        tick();
        dbg_req = 1; dbg_we = 1; dbg_addr = 8'h00; dbg_wdata = 8'h00; dbg_lock = 1;
        @(negedge clock);
        check("t6_lock_gnt", 32'(dbg_gnt), 1);
        tick();
        dbg_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h60;
        repeat ((1 << CNT_W) + 5) tick();
        @(negedge clock);
        check("t6_stall_cnt_sat", 32'(stall_cnt), (1 << CNT_W) - 1);
        check("t6_still_stalled", 32'(cpu_stall), 1);
        check("t6_locked", 32'(locked), 1);
        tick();
        dbg_lock = 0;
        tick();
        @(negedge clock);
        check("t6_unlock_cpu_gnt", 32'(cpu_gnt), 1);
        check("t6_stall_cnt_held", 32'(stall_cnt), (1 << CNT_W) - 1);
        tick();
        idle();
        repeat (RD_LAT + 2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
